// File: rtl/serial_receiver.sv
// serial_receiver: start/data/[parity]/stop UART-style deserializer, one bit per clock edge; optional even parity via SERIAL_RECEIVER_PARITY_EN
module serial_receiver #(
  parameter int WIDTH = 8
) (
  input  logic             clockpulse,
  input  logic             clear_,
  input  logic             data,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             framing_error,
  output logic             overrun,
  output logic             parity_error
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef SERIAL_RECEIVER_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  logic par;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
  assign parity_error = 1'b0;
`endif
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] shreg;
  // frame FSM with registered word handshake and error flags
  always_ff @(posedge clockpulse or negedge clear_) begin
    if (!clear_) begin
      state         <= IDLE;
      cnt           <= '0;
      shreg         <= '0;
      word          <= '0;
      word_valid    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
`ifdef SERIAL_RECEIVER_PARITY_EN
      par           <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      framing_error <= 1'b0;
`ifdef SERIAL_RECEIVER_PARITY_EN
      parity_error  <= 1'b0;
`endif
      if (word_valid && word_ready) word_valid <= 1'b0;
      case (state)
        IDLE: if (!data) begin
          state <= DATA;
          cnt   <= '0;
        end
        DATA: begin
          shreg[cnt] <= data;
          cnt        <= cnt + CW'(1);
`ifdef SERIAL_RECEIVER_PARITY_EN
          if (cnt == LAST) state <= PARITY;
`else
          if (cnt == LAST) state <= STOP;
`endif
        end
`ifdef SERIAL_RECEIVER_PARITY_EN
        PARITY: begin
          par   <= data;
          state <= STOP;
        end
`endif
        STOP: begin
          state <= IDLE;
          if (!data) framing_error <= 1'b1;
`ifdef SERIAL_RECEIVER_PARITY_EN
          else if (^{shreg, par}) parity_error <= 1'b1;
`endif
          else if (!word_valid || word_ready) begin
            word       <= shreg;
            word_valid <= 1'b1;
          end else overrun <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver: directed plus randomized frames checked against a frame-level reference model
module tb_serial_receiver;
  localparam int W = 8;
`ifdef SERIAL_RECEIVER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clockpulse = 1'b0;
  logic clear_, data, word_ready;
  logic [W-1:0] word;
  logic word_valid, framing_error, overrun, parity_error;
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_word;
  logic exp_valid, exp_overrun;

  serial_receiver #(.WIDTH(W)) dut (
    .clockpulse(clockpulse), .clear_(clear_), .data(data),
    .word(word), .word_valid(word_valid), .word_ready(word_ready),
    .framing_error(framing_error), .overrun(overrun), .parity_error(parity_error)
  );

  always #5 clockpulse = ~clockpulse;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic b);
    data = b;
    @(posedge clockpulse);
    @(negedge clockpulse);
  endtask

  task automatic do_reset();
    data = 1'b1;
    #2 clear_ = 1'b0;
    #1;
    chk("rst_word", 32'(word), 0);
    chk("rst_valid", 32'(word_valid), 0);
    chk("rst_ferr", 32'(framing_error), 0);
    chk("rst_perr", 32'(parity_error), 0);
    chk("rst_overrun", 32'(overrun), 0);
    @(negedge clockpulse);
    clear_ = 1'b1;
    exp_word = '0;
    exp_valid = 1'b0;
    exp_overrun = 1'b0;
  endtask

  task automatic consume();
    data = 1'b1;
    word_ready = 1'b1;
    @(posedge clockpulse);
    @(negedge clockpulse);
    word_ready = 1'b0;
    exp_valid = 1'b0;
    chk("consume_valid", 32'(word_valid), 32'(exp_valid));
    chk("consume_word", 32'(word), 32'(exp_word));
  endtask

  task automatic send_frame(input logic [W-1:0] v, input logic stop, input logic par_bad, input logic rdy);
    logic good;
    tick(1'b0);
    for (int i = 0; i < W; i++) tick(v[i]);
    if (PAR) tick(^v ^ par_bad);
    good = stop && !(par_bad && PAR);
    chk("pre_stop_valid", 32'(word_valid), 32'(exp_valid));
    word_ready = rdy;
    tick(stop);
    word_ready = 1'b0;
    data = 1'b1;
    if (good) begin
      if (!exp_valid || rdy) begin
        exp_word = v;
        exp_valid = 1'b1;
      end else exp_overrun = 1'b1;
    end else if (rdy) exp_valid = 1'b0;
    chk("word", 32'(word), 32'(exp_word));
    chk("valid", 32'(word_valid), 32'(exp_valid));
    chk("overrun", 32'(overrun), 32'(exp_overrun));
    chk("framing_error", 32'(framing_error), 32'(!stop));
    chk("parity_error", 32'(parity_error), 32'(stop && par_bad && PAR));
  endtask

  initial begin
    logic [W-1:0] v;
    clear_ = 1'b0;
    data = 1'b1;
    word_ready = 1'b0;
    exp_word = '0;
    exp_valid = 1'b0;
    exp_overrun = 1'b0;
    @(negedge clockpulse);
    do_reset();
    send_frame(8'h9A, 1'b1, 1'b0, 1'b0);
    consume();
    do_reset();
    send_frame(8'h9A, 1'b0, 1'b0, 1'b0);
    tick(1'b1);
    chk("ferr_pulse_end", 32'(framing_error), 0);
    chk("ferr_word_hold", 32'(word), 0);
    do_reset();
    send_frame(8'h9A, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    consume();
    tick(1'b1);
    chk("overrun_sticky", 32'(overrun), 1);
    do_reset();
    send_frame(8'h9A, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    do_reset();
    v = 8'hF7;
    tick(1'b0);
    for (int i = 0; i < 4; i++) tick(v[i]);
    do_reset();
    for (int i = 4; i < W; i++) tick(v[i]);
    if (PAR) tick(^v);
    tick(1'b1);
    tick(1'b1);
    chk("abandoned_valid", 32'(word_valid), 0);
    chk("abandoned_word", 32'(word), 0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    if (PAR) begin
      do_reset();
      send_frame(8'h9A, 1'b1, 1'b0, 1'b0);
      consume();
      send_frame(8'h9A, 1'b1, 1'b1, 1'b0);
      tick(1'b1);
      chk("perr_pulse_end", 32'(parity_error), 0);
    end
    do_reset();
    for (int n = 0; n < 30; n++) begin
      v = W'($urandom);
      send_frame(v, $urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) consume();
      for (int g = $urandom_range(0, 2); g > 0; g--) tick(1'b1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
